// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: row drive patterns, FSM states,
// frame classification and small combinational helpers.
package keypad_pkg;

  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_class_t;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] drv;
    case (idx)
      2'd0:    drv = ROW0;
      2'd1:    drv = ROW1;
      2'd2:    drv = ROW2;
      default: drv = ROW3;
    endcase
    return drv;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row scanner: divider, one-hot-low row rotation, column synchronizer and
// per-frame NONE/SINGLE/MULTI classification with a one-cycle frame_done strobe.
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 2500
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   keypad_col,
  output logic [3:0]   keypad_row,
  output logic         frame_done,
  output frame_class_t frame_class,
  output logic [3:0]   frame_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [1:0]       acc_cnt;
  logic [3:0]       acc_code;

  logic             sample_en;
  logic [3:0]       row_low;
  logic [2:0]       row_n;
  logic [2:0]       sum;
  logic [1:0]       sum_sat;
  logic [3:0]       code_next;
  frame_class_t     class_next;

  assign sample_en = (div_cnt == DIV_LAST);
  assign row_low   = ~col_sync;
  assign row_n     = popcount4(row_low);
  assign sum       = {1'b0, acc_cnt} + row_n;

  // Key count is kept saturated at 2: anything beyond one key is MULTI.
  always_comb begin
    sum_sat    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_next  = (acc_cnt == 2'd0 && row_n == 3'd1) ? {row_idx, lowest_set(row_low)} : acc_code;
    class_next = CLS_NONE;
    case (sum_sat)
      2'd0:    class_next = CLS_NONE;
      2'd1:    class_next = CLS_SINGLE;
      default: class_next = CLS_MULTI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_meta    <= 4'b1111;
      col_sync    <= 4'b1111;
      div_cnt     <= '0;
      row_idx     <= '0;
      keypad_row  <= ROW0;
      acc_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_class <= CLS_NONE;
    end else begin
      col_meta   <= keypad_col;
      col_sync   <= col_meta;
      frame_done <= 1'b0;
      if (sample_en) begin
        div_cnt    <= '0;
        row_idx    <= row_idx + 2'd1;
        keypad_row <= row_drive(row_idx + 2'd1);
        if (row_idx == 2'd3) begin
          frame_done  <= 1'b1;
          frame_class <= class_next;
          acc_cnt     <= '0;
        end else begin
          acc_cnt <= sum_sat;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Code registers are only meaningful alongside a SINGLE count, so no reset.
  always_ff @(posedge clock) begin
    if (sample_en) begin
      if (row_idx == 2'd3) frame_code <= code_next;
      else                 acc_code   <= code_next;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: frame-based debounce FSM producing one key_valid pulse
// per physical press, plus held and multi-key indications.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 2500,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keypad_col,
  output logic [3:0] keypad_row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       multi_key
);

  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(DEBOUNCE_FRAMES);

  logic         frame_done;
  frame_class_t frame_class;
  logic [3:0]   frame_code;

  state_t       state;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_inc;
  logic         last_frame;
  logic [3:0]   cand;

  keypad_row_driver #(
    .SCAN_DIV(SCAN_DIV)
  ) u_row_driver (
    .clock      (clock),
    .reset      (reset),
    .keypad_col (keypad_col),
    .keypad_row (keypad_row),
    .frame_done (frame_done),
    .frame_class(frame_class),
    .frame_code (frame_code)
  );

  assign fcnt_inc   = (fcnt == FCNT_MAX) ? fcnt : fcnt + FW'(1);
  assign last_frame = (fcnt_inc == FCNT_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fcnt      <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_key <= 1'b0;
      if (frame_done) begin
        multi_key <= (frame_class == CLS_MULTI);
        case (state)
          IDLE: begin
            if (frame_class == CLS_SINGLE) begin
              fcnt  <= FW'(1);
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (frame_class == CLS_SINGLE && frame_code == cand) begin
              if (last_frame) begin
                state     <= PRESSED;
                fcnt      <= '0;
                key_valid <= 1'b1;
                key_code  <= cand;
                key_held  <= 1'b1;
              end else begin
                fcnt <= fcnt_inc;
              end
            end else begin
              state <= IDLE;
              fcnt  <= '0;
            end
          end
          // Any key activity while pressed is ignored; a new event needs a full release.
          PRESSED: begin
            if (frame_class == CLS_NONE) begin
              state <= RELEASE;
              fcnt  <= FW'(1);
            end
          end
          RELEASE: begin
            if (frame_class == CLS_NONE) begin
              if (last_frame) begin
                state    <= IDLE;
                fcnt     <= '0;
                key_held <= 1'b0;
              end else begin
                fcnt <= fcnt_inc;
              end
            end else begin
              state <= PRESSED;
              fcnt  <= '0;
            end
          end
          default: begin
            state <= IDLE;
            fcnt  <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (frame_done && state == IDLE && frame_class == CLS_SINGLE) cand <= frame_code;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage for the game core. Drives the 4x4 matrix keypad rows, samples the columns and debounces over whole scan frames.
- Emits exactly one registered, single-cycle key event per physical press, with a stable 4-bit position code.
- Replaces ad-hoc scanning in the top level. The game core consumes key_valid/key_code to mark cells in the active dot-matrix area.

Parameters:
- SCAN_DIV, 2500: clocks per row period (>=4). Columns are sampled at the end of each row period.
- DEBOUNCE_FRAMES, 4: consecutive identical full frames required to accept a press or a release (>=2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- keypad_col  in  4  column inputs, active-low, asynchronous to clock
- keypad_row  out  4  row drive, one-hot active-low
- key_valid  out  1  one-cycle pulse: debounced press accepted
- key_code  out  4  code of last accepted key, row*4+col
- key_held  out  1  high from acceptance until release is debounced
- multi_key  out  1  one-cycle pulse at frame end if more than one key is seen in that frame

Behaviour:
- Reset (async, reset=0), all values immediate:
  - keypad_row=4'b1110, key_valid=0, key_code=0, key_held=0, multi_key=0.
  - Divider, row index and counters =0. Synchronizer=4'b1111. FSM=IDLE.
- Column sync: 2-flop synchronizer on keypad_col. All logic uses only the synchronized value.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps.
- On the edge where div_cnt==SCAN_DIV-1:
  - Sample the synchronized columns for the current row.
  - Advance the row: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Row index r: 0..3 in that order.
- Column c: bit c low means pressed, c=0..3. Code = 4*r + c.
- Frame = 4 row periods, ending at the sample of r=3. Frame result is registered at that edge:
  - NONE: no low bits in any row.
  - SINGLE(code): exactly one low bit in the whole frame.
  - MULTI: otherwise.
- FSM evaluates the registered frame result on the clock after frame end. Outputs are registered on that edge.
- Cycle-level latency: key_valid is high exactly one clock, starting one clock after the frame-end sample edge of the accepting frame.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. fcnt is the frame counter.
  - IDLE:
    - SINGLE(k): cand=k, fcnt=1, go to DEBOUNCE.
    - Otherwise: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): fcnt+1.
    - When fcnt+1==DEBOUNCE_FRAMES: go to PRESSED; key_valid=1 for one cycle; key_code=cand; key_held=1.
    - SINGLE(other), NONE or MULTI: go to IDLE, fcnt=0. The new candidate is not taken in the same frame.
  - PRESSED:
    - NONE: go to RELEASE, fcnt=1.
    - SINGLE (any code) or MULTI: stay in PRESSED, no new event. Roll-over needs a full release first.
  - RELEASE:
    - NONE: fcnt+1. When fcnt+1==DEBOUNCE_FRAMES: go to IDLE, key_held=0.
    - SINGLE or MULTI: go back to PRESSED, fcnt=0, no event.
- multi_key pulses once per MULTI frame in any state, in the same cycle as the FSM evaluation.
- key_code holds its value until the next accepted press. It is never cleared except by reset.
- Counters saturate and never wrap. fcnt width is clog2(DEBOUNCE_FRAMES+1).
- Reset mid-frame or mid-debounce discards all progress. Scanning restarts at row 0 on the first clock after release.
- Minimum press-to-event latency: 2 sync clocks + DEBOUNCE_FRAMES*4*SCAN_DIV clocks + 1.

Decomposition:
- Shared package (keypad_pkg):
  - Row drive constants ROW0..ROW3 = 4'b1110, 4'b1101, 4'b1011, 4'b0111.
  - FSM state encoding IDLE=0, DEBOUNCE=1, PRESSED=2, RELEASE=3.
  - Frame-result encoding NONE/SINGLE/MULTI.
- Sub-module keypad_row_driver:
  - Contains the divider, row rotation, column synchronizer and per-frame classification.
  - Outputs a frame_done strobe, result class and code.
- Parent keypad_scan_debounce holds the debounce FSM and the output registers.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 clocks.)
1. Reset: assert reset mid-run -> immediately keypad_row=1110 and all outputs 0. After release, keypad_row=1101 after 4 clocks and returns to 1110 after 16 clocks.
2. Clean press: model drives keypad_col=1011 only while keypad_row==1101, held for 6 frames -> exactly one key_valid pulse with key_code=6 and key_held=1. After the model releases, key_held=0 after 3 NONE frames.
3. Bounce rejection: key 9 pressed 1 frame, released 1 frame, pressed 2 frames, released -> no key_valid; key_held stays 0.
4. Two keys: key 0 (row 1110, col 1110) and key 11 (row 1011, col 0111) held together -> no key_valid; multi_key pulses once per frame; key_code unchanged.
5. Hold and re-press: key 15 held 10 frames -> one pulse only. Release 3 frames, press key 0 for 3 frames -> second pulse, key_code=0.
6. Release glitch: key 5 accepted, then 1 NONE frame, then key 5 again -> stays in PRESSED with no second pulse; key_held never drops.
